// File: rtl/fp27_pkg.sv
// Shared FP27 definitions for the raymarch core.
// FP27 layout: [26] sign, [25:18] exponent (bias 127), [17:0] mantissa (hidden 1).
// Zero is the all-zero word; there are no denormals and no negative zero.
// Also holds the ray generator's state encoding.
package fp27_pkg;

    localparam int FP27_W        = 27;
    localparam int FP27_EXP_W    = 8;
    localparam int FP27_MAN_W    = 18;
    localparam int FP27_SIGN_BIT = 26;
    localparam int FP27_BIAS     = 127;

    typedef logic [FP27_W-1:0] fp27_t;

    localparam fp27_t FP27_ZERO = '0;
    localparam fp27_t FP27_ONE  = 27'h1FC0000;  // {0, 8'h7F, 18'h0} = 1.0

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } raygen_state_t;

endpackage

// File: rtl/fp27_from_int.sv
// Exact conversion of a signed 12-bit integer, scaled by 2^-SHIFT, to FP27.
// Pure combinational; any 12-bit magnitude fits in the 18-bit mantissa.
// Ports:
//   i_val  in   12  two's complement integer
//   o_fp   out  27  FP27 value of i_val * 2^-SHIFT (0 -> 27'd0)
module fp27_from_int
    import fp27_pkg::*;
#(
    parameter int unsigned SHIFT = 9
) (
    input  logic [11:0] i_val,
    output logic [26:0] o_fp
);

    logic        neg;
    logic [11:0] mag;
    logic [3:0]  lead;
    logic [29:0] norm;
    logic [7:0]  expo;

    always_comb begin
        neg  = i_val[11];
        mag  = neg ? 12'(-i_val) : i_val;
        lead = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (mag[i]) lead = 4'(i);
        end
        // Shift the leading one to bit 18 so bits [17:0] are the fraction.
        norm = {mag, 18'b0} >> lead;
        expo = 8'(FP27_BIAS + int'(lead) - int'(SHIFT));
        if (mag == '0) o_fp = FP27_ZERO;
        else           o_fp = {neg, expo, norm[17:0]};
    end

endmodule

// File: rtl/ray_dir_gen.sv
// Per-frame raster scanner emitting one unnormalized FP27 camera-space ray per pixel:
// {(x-H/2)*2^-S, (V/2-y)*2^-S, FOCAL}, with a valid/ready output handshake.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_start         start-of-frame pulse, honoured only in IDLE
//   i_ready         downstream accepts the current ray
//   o_valid         ray outputs valid
//   o_dir_x/y/z     FP27 direction components
//   o_pix_x/y       pixel tag of the current ray
//   o_last          current ray is pixel (H_RES-1, V_RES-1)
//   o_busy          frame in progress (RUN)
//   o_frame_done    one-cycle pulse after the last ray is accepted
module ray_dir_gen
    import fp27_pkg::*;
#(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned SCALE_SHIFT = 9,
    parameter logic [26:0] FOCAL       = 27'h1FC0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [26:0] o_dir_x,
    output logic [26:0] o_dir_y,
    output logic [26:0] o_dir_z,
    output logic [10:0] o_pix_x,
    output logic [10:0] o_pix_y,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_frame_done
);

    raygen_state_t state, state_nxt;
    logic          load;
    logic          retire;
    logic          handshake;
    logic [10:0]   nxt_x, nxt_y;
    logic [11:0]   dx, dy;
    logic [26:0]   fx, fy;
    logic          nxt_last;

    assign handshake = o_valid & i_ready;

    // The output pixel tags double as the raster counters; the next pixel is
    // derived from them (or forced to (0,0) when a frame starts).
    always_comb begin
        nxt_x = '0;
        nxt_y = '0;
        if (state == RUN) begin
            if (o_pix_x == 11'(H_RES - 1)) begin
                nxt_x = '0;
                nxt_y = o_pix_y + 11'd1;
            end else begin
                nxt_x = o_pix_x + 11'd1;
                nxt_y = o_pix_y;
            end
        end
        dx       = {1'b0, nxt_x} - 12'(H_RES / 2);
        dy       = 12'(V_RES / 2) - {1'b0, nxt_y};
        nxt_last = (nxt_x == 11'(H_RES - 1)) && (nxt_y == 11'(V_RES - 1));
    end

    fp27_from_int #(.SHIFT(SCALE_SHIFT)) u_conv_x (.i_val(dx), .o_fp(fx));
    fp27_from_int #(.SHIFT(SCALE_SHIFT)) u_conv_y (.i_val(dy), .o_fp(fy));

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (handshake) begin
                    if (o_last) begin
                        state_nxt = DONE;
                        retire    = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || retire) begin
            o_valid <= 1'b0;
            o_dir_x <= '0;
            o_dir_y <= '0;
            o_dir_z <= '0;
            o_pix_x <= '0;
            o_pix_y <= '0;
            o_last  <= 1'b0;
        end else if (load) begin
            o_valid <= 1'b1;
            o_dir_x <= fx;
            o_dir_y <= fy;
            o_dir_z <= FOCAL;
            o_pix_x <= nxt_x;
            o_pix_y <= nxt_y;
            o_last  <= nxt_last;
        end
    end

    assign o_busy       = (state == RUN);
    assign o_frame_done = (state == DONE);

endmodule
